// File: rtl/mem_pkg.sv
// mem_pkg: types and constants shared by the memory arbiter slice.
//   MEM_W_*      : access-width encoding on the memory bus
//   arb_state_t  : arbiter FSM states
//   owner_t      : which requester currently owns the memory port
package mem_pkg;

  localparam logic [1:0] MEM_W_BYTE = 2'b00;
  localparam logic [1:0] MEM_W_HALF = 2'b01;
  localparam logic [1:0] MEM_W_WORD = 2'b10;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups the fetch (i_*), data (d_*) and memory-side signals
// that meet at the arbiter.
//   master : arbiter view (takes both requests and the memory ack/data,
//            drives acks, read data and the forwarded memory request)
//   slave  : environment view (stages + memory model), directions mirrored
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_data;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_write;
  logic [31:0] d_data_out;
  logic        d_extend;
  logic [1:0]  d_width;
  logic        d_ack;
  logic [31:0] d_data_in;
  logic        req;
  logic [31:0] addr;
  logic        write;
  logic [31:0] data_out;
  logic        extend;
  logic [1:0]  width;
  logic        ack;
  logic [31:0] data_in;

  modport master (
    input  i_req, i_addr, d_req, d_addr, d_write, d_data_out, d_extend, d_width,
           ack, data_in,
    output i_ack, i_data, d_ack, d_data_in, req, addr, write, data_out, extend,
           width
  );

  modport slave (
    output i_req, i_addr, d_req, d_addr, d_write, d_data_out, d_extend, d_width,
           ack, data_in,
    input  i_ack, i_data, d_ack, d_data_in, req, addr, write, data_out, extend,
           width
  );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of cycles fetch has been kept waiting.
//   clk, reset_n : clock, synchronous active-low reset
//   i_waiting    : fetch is requesting but does not own the port this cycle
//   i_clear      : fetch completed or stopped requesting
//   o_starve     : count reached FETCH_MAX_WAIT (never set when it is 0)
module mem_arb_starve_ctr #(
  parameter int FETCH_MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_waiting,
  input  logic i_clear,
  output logic o_starve
);

  localparam int CW = (FETCH_MAX_WAIT > 0) ? $clog2(FETCH_MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] MAXV = CW'(FETCH_MAX_WAIT);

  logic [CW-1:0] r_cnt;

  // clear takes precedence so the cycle of i_ack always leaves the count at 0
  always_ff @(posedge clk) begin
    if (!reset_n)                     r_cnt <= '0;
    else if (i_clear)                 r_cnt <= '0;
    else if (i_waiting && r_cnt != MAXV) r_cnt <= r_cnt + 1'b1;
  end

  assign o_starve = (FETCH_MAX_WAIT != 0) && (r_cnt == MAXV);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (I, read
// only) and the mem stage (D). D has fixed priority; a starvation counter
// gives I one grant after FETCH_MAX_WAIT lost cycles. A grant that does not
// complete in its first cycle is locked until ack or until the owner drops
// its request (flush).
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : mem_arbiter_if.master (fetch, data and memory signals)
// Optional: define MEM_ARB_STATS_EN to add 32-bit wrapping counters
//   stat_i_xfers, stat_d_xfers, stat_conflict_cycles, stat_starve_grants.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int FETCH_MAX_WAIT = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.master bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]  stat_i_xfers,
  output logic [31:0]  stat_d_xfers,
  output logic [31:0]  stat_conflict_cycles,
  output logic [31:0]  stat_starve_grants
`endif
);

  arb_state_t r_state;
  owner_t     w_own;
  logic       w_own_req;
  logic       w_ack;
  logic       w_starve;

  // Owner: locked while in a grant state, otherwise picked this cycle so a
  // combinational ack completes the transfer with no added latency. With no
  // requester the owner defaults to D, whose req is then 0.
  always_comb begin
    w_own = OWN_D;
    case (r_state)
      ARB_GNT_I: w_own = OWN_I;
      ARB_GNT_D: w_own = OWN_D;
      default: begin
        if (w_starve && bus.i_req) w_own = OWN_I;
        else if (bus.d_req)        w_own = OWN_D;
        else if (bus.i_req)        w_own = OWN_I;
        else                       w_own = OWN_D;
      end
    endcase
  end

  assign w_own_req = (w_own == OWN_I) ? bus.i_req : bus.d_req;

  assign bus.req      = reset_n & w_own_req;
  assign bus.addr     = (w_own == OWN_I) ? bus.i_addr : bus.d_addr;
  assign bus.write    = (w_own == OWN_I) ? 1'b0       : bus.d_write;
  assign bus.data_out = bus.d_data_out;
  assign bus.extend   = (w_own == OWN_I) ? 1'b0       : bus.d_extend;
  assign bus.width    = (w_own == OWN_I) ? MEM_W_WORD : bus.d_width;

  // an ack with no outstanding req (e.g. after a flush) is dropped
  assign w_ack      = bus.ack & bus.req;
  assign bus.i_ack  = w_ack & (w_own == OWN_I);
  assign bus.d_ack  = w_ack & (w_own == OWN_D);
  assign bus.i_data    = bus.data_in;
  assign bus.d_data_in = bus.data_in;

  mem_arb_starve_ctr #(.FETCH_MAX_WAIT(FETCH_MAX_WAIT)) u_starve (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_waiting (bus.i_req & (w_own != OWN_I)),
    .i_clear   (bus.i_ack | ~bus.i_req),
    .o_starve  (w_starve)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
    end else begin
      case (r_state)
        ARB_IDLE:
          if (w_own_req && !bus.ack)
            r_state <= (w_own == OWN_I) ? ARB_GNT_I : ARB_GNT_D;
        default:
          if (!w_own_req || bus.ack) r_state <= ARB_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // a starve grant is one the counter actually decided: D was also asking
  logic w_forced;
  assign w_forced = (r_state == ARB_IDLE) & w_starve & bus.i_req & bus.d_req;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_i_xfers         <= '0;
      stat_d_xfers         <= '0;
      stat_conflict_cycles <= '0;
      stat_starve_grants   <= '0;
    end else begin
      if (bus.i_ack)               stat_i_xfers         <= stat_i_xfers + 32'd1;
      if (bus.d_ack)               stat_d_xfers         <= stat_d_xfers + 32'd1;
      if (bus.i_req && bus.d_req)  stat_conflict_cycles <= stat_conflict_cycles + 32'd1;
      if (w_forced)                stat_starve_grants   <= stat_starve_grants + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MAXW = 3;
  localparam logic [31:0] IA  = 32'h0000_1000;
  localparam logic [31:0] DA  = 32'h0000_2004;
  localparam logic [31:0] DWD = 32'hDEAD_BEEF;
  localparam logic [31:0] DAT = 32'hCAFE_F00D;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_arbiter_if bif();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] s_ix, s_dx, s_cf, s_sg;
`endif

  mem_arbiter #(.FETCH_MAX_WAIT(MAXW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_i_xfers         (s_ix),
    .stat_d_xfers         (s_dx),
    .stat_conflict_cycles (s_cf),
    .stat_starve_grants   (s_sg)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_lock: 0 = port free, 1 = I holds it, 2 = D holds it
  int m_lock = 0;
  int m_wait = 0;
  int e_own;
  logic e_req, e_iack, e_dack;
  logic [31:0] m_ix = 0, m_dx = 0, m_cf = 0, m_sg = 0;

  task automatic eval_model();
    int own;
    if (m_lock != 0) own = m_lock;
    else if (MAXW != 0 && m_wait == MAXW && bif.i_req) own = 1;
    else if (bif.d_req) own = 2;
    else if (bif.i_req) own = 1;
    else own = 0;
    e_own  = own;
    e_req  = reset_n && ((own == 1 && bif.i_req) || (own == 2 && bif.d_req));
    e_iack = e_req && bif.ack && own == 1;
    e_dack = e_req && bif.ack && own == 2;
  endtask

  task automatic update_model();
    if (!reset_n) begin
      m_lock = 0; m_wait = 0;
      m_ix = 0; m_dx = 0; m_cf = 0; m_sg = 0;
    end else begin
      if (e_iack) m_ix++;
      if (e_dack) m_dx++;
      if (bif.i_req && bif.d_req) m_cf++;
      if (m_lock == 0 && e_own == 1 && bif.d_req) m_sg++;
      if (e_iack || !bif.i_req) m_wait = 0;
      else if (e_own != 1 && m_wait < MAXW) m_wait++;
      if (m_lock == 0) begin
        if (e_req && !bif.ack) m_lock = e_own;
      end else if (!e_req || bif.ack) m_lock = 0;
    end
  endtask

  task automatic cyc_end();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic drive(input logic rst, input logic ir, input logic dr,
                       input logic dw, input logic ak);
    reset_n     = rst;
    bif.i_req   = ir;
    bif.d_req   = dr;
    bif.d_write = dw;
    bif.ack     = ak;
  endtask

  task automatic check_model(input int cyc);
    chk($sformatf("r%0d_req", cyc),   {31'b0, bif.req},   {31'b0, e_req});
    chk($sformatf("r%0d_i_ack", cyc), {31'b0, bif.i_ack}, {31'b0, e_iack});
    chk($sformatf("r%0d_d_ack", cyc), {31'b0, bif.d_ack}, {31'b0, e_dack});
    chk($sformatf("r%0d_i_data", cyc), bif.i_data, bif.data_in);
    chk($sformatf("r%0d_d_data", cyc), bif.d_data_in, bif.data_in);
    if (e_req) begin
      if (e_own == 1) begin
        chk($sformatf("r%0d_addrI", cyc), bif.addr, bif.i_addr);
        chk($sformatf("r%0d_ctlI", cyc), {28'b0, bif.write, bif.extend, bif.width},
            {28'b0, 1'b0, 1'b0, 2'b10});
      end else begin
        chk($sformatf("r%0d_addrD", cyc), bif.addr, bif.d_addr);
        chk($sformatf("r%0d_wdat", cyc), bif.data_out, bif.d_data_out);
        chk($sformatf("r%0d_ctlD", cyc), {28'b0, bif.write, bif.extend, bif.width},
            {28'b0, bif.d_write, bif.d_extend, bif.d_width});
      end
    end
`ifdef MEM_ARB_STATS_EN
    chk($sformatf("r%0d_st_i", cyc),  s_ix, m_ix);
    chk($sformatf("r%0d_st_d", cyc),  s_dx, m_dx);
    chk($sformatf("r%0d_st_cf", cyc), s_cf, m_cf);
    chk($sformatf("r%0d_st_sg", cyc), s_sg, m_sg);
`endif
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [4:0] in;   // {reset_n, i_req, d_req, d_write, ack}
    logic [2:0] ex;   // {req, i_ack, d_ack}
    int         src;  // 0 = fields not checked, 1 = from I, 2 = from D
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [4:0] in, input logic [2:0] ex, input int src, input int n);
    vec_t v;
    v.in = in; v.ex = ex; v.src = src;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bif.i_addr = IA; bif.d_addr = DA; bif.d_data_out = DWD;
    bif.d_extend = 1'b1; bif.d_width = 2'b01; bif.data_in = DAT;

    add(5'b01101, 3'b000, 0, 2);  // held in reset: nothing forwarded
    add(5'b11001, 3'b110, 1, 3);  // fetch alone, ack tied high
    add(5'b11110, 3'b100, 2, 2);  // conflict, D store wins, ack late
    add(5'b11111, 3'b101, 2, 1);
    add(5'b11001, 3'b110, 1, 1);  // then fetch
    add(5'b11000, 3'b100, 1, 1);  // I granted, ack withheld
    add(5'b11100, 3'b100, 1, 2);  // D arrives: ignored while I locked
    add(5'b11101, 3'b110, 1, 1);
    add(5'b10101, 3'b101, 2, 1);  // D only afterwards
    add(5'b11101, 3'b101, 2, 3);  // starvation: D x3, I, D x3, I
    add(5'b11101, 3'b110, 1, 1);
    add(5'b11101, 3'b101, 2, 3);
    add(5'b11101, 3'b110, 1, 1);
    add(5'b10100, 3'b100, 2, 1);  // D granted, ack withheld
    add(5'b10000, 3'b000, 0, 1);  // D flushes: req drops same cycle
    add(5'b10001, 3'b000, 0, 1);  // late ack is ignored
    add(5'b10111, 3'b101, 2, 1);
    add(5'b11110, 3'b100, 2, 1);  // D granted, then reset mid-transfer
    add(5'b01111, 3'b000, 0, 1);
    add(5'b11101, 3'b101, 2, 3);  // wait count restarted from 0
    add(5'b11101, 3'b110, 1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      @(negedge clk);
      eval_model();
      chk($sformatf("t%0d_req", i),   {31'b0, bif.req},   {31'b0, tbl[i].ex[2]});
      chk($sformatf("t%0d_i_ack", i), {31'b0, bif.i_ack}, {31'b0, tbl[i].ex[1]});
      chk($sformatf("t%0d_d_ack", i), {31'b0, bif.d_ack}, {31'b0, tbl[i].ex[0]});
      chk($sformatf("t%0d_i_data", i), bif.i_data, DAT);
      if (tbl[i].src == 1) begin
        chk($sformatf("t%0d_addrI", i), bif.addr, IA);
        chk($sformatf("t%0d_ctlI", i), {28'b0, bif.write, bif.extend, bif.width}, 32'h2);
      end else if (tbl[i].src == 2) begin
        chk($sformatf("t%0d_addrD", i), bif.addr, DA);
        chk($sformatf("t%0d_ctlD", i), {28'b0, bif.write, bif.extend, bif.width},
            {28'b0, tbl[i].in[1], 1'b1, 2'b01});
        chk($sformatf("t%0d_wdat", i), bif.data_out, DWD);
      end
      cyc_end();
    end

    // hand sequence: D owner flushes while I waits, ack arrives in that cycle
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); eval_model();
    chk("h0_req", {31'b0, bif.req}, 32'd1);
    chk("h0_addr", bif.addr, DA);
    cyc_end();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk); eval_model();
    chk("h1_req", {31'b0, bif.req}, 32'd0);
    chk("h1_acks", {30'b0, bif.i_ack, bif.d_ack}, 32'd0);
    cyc_end();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk); eval_model();
    chk("h2_i_ack", {31'b0, bif.i_ack}, 32'd1);
    chk("h2_addr", bif.addr, IA);
    cyc_end();

    // ---------------- randomized against the model ----------------
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 6), 1'($urandom()), 1'($urandom()));
      bif.i_addr     = $urandom();
      bif.d_addr     = $urandom();
      bif.d_data_out = $urandom();
      bif.d_extend   = 1'($urandom());
      bif.d_width    = 2'($urandom_range(0, 2));
      bif.data_in    = $urandom();
      @(negedge clk);
      eval_model();
      check_model(c);
      cyc_end();
    end

    // final reset: everything cleared on the following cycle
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk); eval_model();
    chk("z0_req", {31'b0, bif.req}, 32'd0);
    cyc_end();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); eval_model();
    chk("z1_req", {31'b0, bif.req}, 32'd0);
`ifdef MEM_ARB_STATS_EN
    chk("z1_stats", s_ix | s_dx | s_cf | s_sg, 32'd0);
`endif
    cyc_end();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between two requesters: instruction fetch (read-only, I port) and the mem stage (load/store, D port).
- Sits between the two stages and the memory model/bus.
- Data has fixed priority. A starvation counter guarantees fetch forward progress.
- Once a transaction is granted it is locked until the memory asserts ack.

Parameters:
- FETCH_MAX_WAIT, 8: cycles fetch may wait while losing to D before it gets priority for one grant. 0 = pure D priority, counter unused.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  32  fetch address
- i_ack  out  1  fetch transfer complete
- i_data  out  32  fetch read data, valid with i_ack
- d_req  in  1  data request, held until d_ack
- d_addr  in  32  data address
- d_write  in  1  1 = store
- d_data_out  in  32  store data
- d_extend  in  1  sign-extend load
- d_width  in  2  access width
- d_ack  out  1  data transfer complete
- d_data_in  out  32  load data, valid with d_ack
- req  out  1  memory request
- addr  out  32  memory address
- write  out  1  memory write
- data_out  out  32  memory write data
- extend  out  1  memory sign-extend
- width  out  2  memory width
- ack  in  1  memory ack; may be combinational in the same cycle as req
- data_in  in  32  memory read data

Behaviour:
- Width encoding (mem_pkg): 00 byte, 01 half, 10 word.
- Fetch is forwarded as write=0, extend=0, width=10.
- FSM states: IDLE, GNT_I, GNT_D. Reset value is IDLE; wait_cnt = 0.
- While reset_n = 0: req = 0, i_ack = 0, d_ack = 0.
- IDLE arbitration is combinational, adding zero cycles of latency:
  - If starve (wait_cnt == FETCH_MAX_WAIT and FETCH_MAX_WAIT != 0) and i_req, the owner is I.
  - Otherwise, if d_req, the owner is D.
  - Otherwise, if i_req, the owner is I.
  - Otherwise there is no owner, req = 0, and all forwarded fields are from D (don't-care).
- req = owner's req. addr, write, data_out, extend and width are muxed from the owner.
- owner_ack = ack & req; the non-owner's ack is 0.
- i_data = d_data_in = data_in (broadcast). Consumers qualify it with their own ack.
- IDLE with owner and ack in the same cycle: transfer completes, state stays IDLE (back-to-back transfers possible every cycle).
- IDLE with owner and no ack: go to GNT_I/GNT_D; the owner is latched.
- GNT_x: the owner is locked, and the other requester is ignored even if it has higher priority.
  - ack returns the FSM to IDLE.
  - If the owner drops req before ack (flush), req drops the same cycle and the FSM returns to IDLE next cycle. A later ack in IDLE with req = 0 is ignored.
- wait_cnt:
  - Increments each cycle i_req = 1 and I is not owner, saturating at FETCH_MAX_WAIT.
  - Clears on the cycle i_ack = 1.
  - Clears if i_req = 0.
- Simultaneous i_req and d_req with no starvation: D wins. I sees i_ack = 0 and waits.
- A reset mid-transaction abandons it: the FSM goes to IDLE and no ack is forwarded.

Optional Feature:
- Macro MEM_ARB_STATS_EN adds 32-bit wrapping counters as outputs:
  - stat_i_xfers: counts i_ack.
  - stat_d_xfers: counts d_ack.
  - stat_conflict_cycles: counts i_req & d_req cycles.
  - stat_starve_grants: counts grants to I forced by the starve condition.
- All four reset to 0.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- mem_pkg holds:
  - width localparams MEM_W_BYTE/HALF/WORD;
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_GNT_I, ARB_GNT_D};
  - typedef enum logic owner_t {OWN_I, OWN_D}.
- One sub-module, mem_arb_starve_ctr: the saturating wait counter with param FETCH_MAX_WAIT, inputs waiting/clear, output starve.

Test Plan:
- i_req only, ack tied 1 -> req same cycle, addr = i_addr, width = 10, write = 0; i_ack = 1 every cycle; d_ack = 0.
- i_req and d_req together, d_write = 1, ack after 2 cycles -> D owns for 3 cycles, d_ack in cycle 3, then I is granted next cycle.
- I granted, ack delayed 3 cycles, d_req asserted in cycle 1 -> owner stays I until i_ack; D is granted only afterwards.
- FETCH_MAX_WAIT = 3, d_req held high, i_req high, ack = 1 -> D granted 3 cycles, then I in cycle 4 (wait_cnt = 3), then D resumes; wait_cnt reads 0 after i_ack.
- D granted, ack withheld, d_req drops in cycle 2 -> req = 0 that cycle, state IDLE next cycle; a late ack produces no d_ack or i_ack.
- reset_n = 0 during GNT_D -> next cycle state IDLE, req = 0, wait_cnt = 0, and stats = 0 with MEM_ARB_STATS_EN.
